// File: rtl/dp_ram_stream_reader_pkg.sv
// dp_ram_rd_pkg
// Shared state encoding and default buffer depth for the dual-port RAM
// stream reader and its output FIFO.

package dp_ram_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int DEFAULT_FIFO_DEPTH = 2;

endpackage

// File: rtl/dp_ram_stream_reader_rd_skid_fifo.sv
// rd_skid_fifo
// Small synchronous FIFO that absorbs RAM read data while the stream consumer
// is stalled. Exposes its occupancy so the reader can issue reads only when a
// slot is guaranteed. Storage is cleared on reset so the head word reads as
// zero straight out of reset.

module rd_skid_fifo
    import dp_ram_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] ptr);
        if (ptr == PTR_WIDTH'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_WIDTH'(1);
    endfunction

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    always_comb begin
        do_pop     = pop && (count != '0);
        do_push    = push && ((count < CNT_WIDTH'(FIFO_DEPTH)) || do_pop);
        head_valid = (count != '0);
        head_data  = mem[rd_ptr];
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_WIDTH'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/dp_ram_stream_reader.sv
// dp_ram_stream_reader
// Drains a contiguous (wrapping) address range from RAM port B into a
// valid/ready stream. Reads are issued only against a guaranteed FIFO slot,
// counting the read still in flight, so backpressure never loses data.
// Optional build macro DP_RAM_RD_STRIDE_EN adds a stride input that replaces
// the fixed address increment of 1.

module dp_ram_stream_reader
    import dp_ram_rd_pkg::*;
#(
    parameter int RAM_DEPTH  = 16,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
`ifdef DP_RAM_RD_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dob,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

    rd_state_t             state;
    rd_state_t             state_nxt;
    logic [ADDR_WIDTH:0]   issue_cnt;
    logic [ADDR_WIDTH:0]   beat_cnt;
    logic                  inflight;
    logic                  pop;
    logic                  last_accept;
    logic                  job_load;
    logic                  job_empty;
    logic [CNT_WIDTH-1:0]  fifo_count;
    logic [CNT_WIDTH:0]    credit_used;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] addr_inc;

`ifdef DP_RAM_RD_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_q;
    assign step = stride_q;
`else
    assign step = ADDR_WIDTH'(1);
`endif

    rd_skid_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight),
        .push_data  (dob),
        .pop        (pop),
        .count      (fifo_count),
        .head_valid (m_valid),
        .head_data  (m_data)
    );

    // Stream handshake, job-level strobes and slot accounting for read credit.
    always_comb begin
        pop         = m_valid && m_ready;
        m_last      = m_valid && (beat_cnt == (ADDR_WIDTH + 1)'(1));
        last_accept = pop && (beat_cnt == (ADDR_WIDTH + 1)'(1));
        busy        = (state != IDLE);
        job_load    = (state == IDLE) && start && (len != '0);
        job_empty   = (state == IDLE) && start && (len == '0);
        credit_used = {1'b0, fifo_count} + (CNT_WIDTH + 1)'(inflight)
                      - (CNT_WIDTH + 1)'(pop);
        addr_inc    = ADDR_WIDTH'((int'(addrb) + int'(step)) % RAM_DEPTH);
    end

    // Next-state and read-enable decode.
    always_comb begin
        state_nxt = state;
        enb       = 1'b0;
        case (state)
            IDLE: begin
                if (job_load) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                enb = (issue_cnt != '0) && (credit_used < (CNT_WIDTH + 1)'(FIFO_DEPTH));
                if (enb && (issue_cnt == (ADDR_WIDTH + 1)'(1))) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, read-in-flight flag and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            inflight <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= enb;
            done     <= job_empty || ((state == DRAIN) && last_accept);
        end
    end

    // Address walker and the issue/beat counters for the current job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrb     <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
`ifdef DP_RAM_RD_STRIDE_EN
            stride_q  <= '0;
`endif
        end else if (job_load) begin
            addrb     <= base_addr;
            issue_cnt <= len;
            beat_cnt  <= len;
`ifdef DP_RAM_RD_STRIDE_EN
            stride_q  <= stride;
`endif
        end else begin
            if (enb) begin
                addrb     <= addr_inc;
                issue_cnt <= issue_cnt - (ADDR_WIDTH + 1)'(1);
            end
            if (pop) begin
                beat_cnt <= beat_cnt - (ADDR_WIDTH + 1)'(1);
            end
        end
    end

endmodule

// File: doc/dp_ram_stream_reader.md
Name: dp_ram_stream_reader

Overview:
- Read-side engine for the simple dual-port RAM: drains a contiguous address range from port B into a valid/ready stream.
- Hides the RAM's 1-cycle registered read latency with a small output FIFO, so there is no data loss and no bubbles under backpressure.
- Sits between a buffer filled by an upstream writer on port A and a downstream compute or DMA consumer.

Parameters:
- RAM_DEPTH, 16, number of addressable words; addresses wrap modulo RAM_DEPTH.
- ADDR_WIDTH, $clog2(RAM_DEPTH), address width.
- DATA_WIDTH, 64, word width.
- FIFO_DEPTH, 2, output buffer entries; must be at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe, honoured only when idle
- base_addr  in  ADDR_WIDTH  first word address, sampled with start
- len  in  ADDR_WIDTH+1  word count, 0..RAM_DEPTH, sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at job completion
- enb  out  1  RAM port-B enable
- addrb  out  ADDR_WIDTH  RAM port-B address
- dob  in  DATA_WIDTH  RAM port-B read data, valid 1 cycle after enb
- m_valid  out  1  stream data valid
- m_ready  in  1  stream consumer ready
- m_data  out  DATA_WIDTH  stream word
- m_last  out  1  marks the final word of the job

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, busy=0, done=0, enb=0, addrb=0, m_valid=0, m_last=0, m_data=0; FIFO empty; counters zeroed.
- Reset mid-job: the job is abandoned; no done pulse is produced and the in-flight read is discarded.
- State IDLE:
  - start with len>0 goes to READ; addrb<=base_addr, issue_cnt<=len, beat_cnt<=len.
  - start with len==0 stays IDLE and pulses done the next cycle; no RAM access.
- State READ:
  - enb is combinational: state==READ and issue_cnt>0 and (occupancy + inflight - pop) < FIFO_DEPTH.
  - pop = m_valid & m_ready.
  - Each cycle enb=1: addrb advances by 1, wrapping from RAM_DEPTH-1 to 0; issue_cnt decrements.
  - When issue_cnt reaches 0, go to DRAIN.
- State DRAIN: waits until the beat carrying m_last is accepted, then goes to IDLE and pulses done in the following cycle.
- Inflight flag: inflight is set on the cycle enb=1. The next cycle, dob is written into the FIFO and inflight clears unless another read is issued.
- Output: m_data and m_valid come from the FIFO head. m_last=1 when the head word is beat number len, i.e. beat_cnt==1, where beat_cnt decrements on each pop.
- Latency: start at edge 0 -> enb high in cycle 1 -> dob in cycle 2 -> m_valid in cycle 3.
- Throughput: with m_ready held high, one word per cycle sustained.
- Backpressure:
  - m_valid held, m_data stable.
  - enb throttles so the FIFO never overflows.
  - No RAM read is ever issued without a guaranteed FIFO slot.
- start while busy is ignored: no effect on the job or its outputs.
- Simultaneous FIFO push and pop on a full FIFO are both allowed only if the credit rule permitted the read; occupancy is unchanged.
- len==RAM_DEPTH: reads every word exactly once, starting at base_addr and wrapping.

Optional Feature:
- Macro: DP_RAM_RD_STRIDE_EN.
- Defined: adds input port stride (ADDR_WIDTH), sampled with start. addrb advances by stride modulo RAM_DEPTH per issued read; stride==0 re-reads base_addr len times.
- Undefined: no stride port; increment fixed at 1.

Decomposition:
- Package dp_ram_rd_pkg: state enum (IDLE, READ, DRAIN) and the FIFO_DEPTH default constant.
- Sub-module rd_skid_fifo: FIFO_DEPTH-entry synchronous FIFO with push/pop, occupancy count, head data/valid and asynchronous active-low reset.
- The reader instantiates one rd_skid_fifo; address, counter and credit logic stay in the top.

Test Plan:
- base_addr=3, len=4, RAM[i]=i+100, m_ready=1 -> m_data 103,104,105,106 on cycles 3..6, m_last on 106, done pulse cycle 7, enb exactly 4 cycles.
- RAM_DEPTH=16, base_addr=14, len=4 -> addrb sequence 14,15,0,1; data matches; m_last on 4th beat.
- len=6, m_ready toggles 1,0,0,1 repeating -> no lost or duplicated words, m_data stable while stalled, enb never drives FIFO occupancy above 2.
- start with len=0 -> done pulse next cycle, enb never asserts, m_valid stays 0; second start while busy -> ignored, beat count unchanged.
- Assert rst_n=0 after 2 of 8 beats -> all outputs 0 asynchronously, no done; new start with len=2 after release -> clean 2-beat job.
- With DP_RAM_RD_STRIDE_EN: base=1, stride=5, len=4, RAM_DEPTH=16 -> addrb 1,6,11,0.
